// File: rtl/shift_pipe_if.sv
// Operand/result handshake bundle for shift_pipe.
// out_sticky exists only when SHIFT_PIPE_STICKY_EN is defined.
interface shift_pipe_if #(
  parameter int DIW = 8,
  parameter int SW  = $clog2(DIW),
  parameter int DOW = 2*DIW-1
);
  logic           in_valid;
  logic           in_ready;
  logic [DIW-1:0] a;
  logic [SW-1:0]  n;
  logic [1:0]     mode;
  logic           out_valid;
  logic           out_ready;
  logic [DOW-1:0] y;
`ifdef SHIFT_PIPE_STICKY_EN
  logic           out_sticky;

  modport master (output in_valid, a, n, mode, out_ready,
                  input  in_ready, out_valid, y, out_sticky);
  modport slave  (input  in_valid, a, n, mode, out_ready,
                  output in_ready, out_valid, y, out_sticky);
`else
  modport master (output in_valid, a, n, mode, out_ready,
                  input  in_ready, out_valid, y);
  modport slave  (input  in_valid, a, n, mode, out_ready,
                  output in_ready, out_valid, y);
`endif
endinterface

// File: rtl/shift_pipe.sv
// Pipelined LSL/LSR/ASR/ROL barrel shifter, one log2 stage per register, valid/ready flow.
// Optional sticky output (OR of bits shifted past bit 0) under SHIFT_PIPE_STICKY_EN.
module shift_pipe #(
  parameter int DIW = 8,
  parameter int SW  = $clog2(DIW),
  parameter int DOW = 2*DIW-1
) (
  input  logic         clk,
  input  logic         rst,
  shift_pipe_if.slave  bus
);
  if (DIW < 2 || (DIW & (DIW-1)) != 0) begin : g_chk
    $error("shift_pipe: DIW must be a power of 2 and >= 2");
  end

  localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROL = 2'b11;

  typedef struct packed {
    logic [DOW-1:0] d;
    logic [1:0]     mode;
    logic [SW-1:0]  n;
`ifdef SHIFT_PIPE_STICKY_EN
    logic           stk;
`endif
  } stg_t;

  stg_t          in_s;
  logic [SW-1:0] vld_q;
  logic          stall;

  // Whole pipe freezes on a blocked output; bubbles travel with the stages.
  assign stall        = vld_q[SW-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign bus.out_valid = vld_q[SW-1];

  always_comb begin
    in_s      = '0;
    in_s.d    = (bus.mode == ASR) ? {{(DOW-DIW){bus.a[DIW-1]}}, bus.a}
                                  : {{(DOW-DIW){1'b0}}, bus.a};
    in_s.mode = bus.mode;
    in_s.n    = bus.n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         vld_q <= '0;
    else if (!stall) vld_q <= (vld_q << 1) | SW'(bus.in_valid);
  end

  for (genvar k = 0; k < SW; k++) begin : g_stg
    localparam int SH = 1 << k;
    stg_t           src, d_d, q;
    logic [DIW-1:0] lo;

    if (k == 0) begin : g_first
      assign src = in_s;
    end else begin : g_next
      assign src = g_stg[k-1].q;
    end

    always_comb begin
      d_d = src;
      lo  = src.d[DIW-1:0];
      if (src.n[k]) begin
        case (src.mode)
          LSL: d_d.d = src.d << SH;
          LSR: begin
            d_d.d = src.d >> SH;
`ifdef SHIFT_PIPE_STICKY_EN
            d_d.stk = src.stk | (|src.d[SH-1:0]);
`endif
          end
          ASR: begin
            d_d.d = $unsigned($signed(src.d) >>> SH);
`ifdef SHIFT_PIPE_STICKY_EN
            d_d.stk = src.stk | (|src.d[SH-1:0]);
`endif
          end
          // Rotation is confined to the low DIW bits; the widened top stays zero.
          default: d_d.d = {{(DOW-DIW){1'b0}}, (lo << SH) | (lo >> (DIW-SH))};
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)         q <= '0;
      else if (!stall) q <= d_d;
    end
  end

  assign bus.y = g_stg[SW-1].q.d;
`ifdef SHIFT_PIPE_STICKY_EN
  assign bus.out_sticky = g_stg[SW-1].q.stk;
`endif

  logic unused_tail;
  assign unused_tail = ^{g_stg[SW-1].q.mode, g_stg[SW-1].q.n};
endmodule
